// File: rtl/ahbuart_arb_pkg.sv
// Shared types and helpers for the ahbuart bus arbiter: FSM state encoding,
// timeout counter width and index-width helper.
package ahbuart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BUS   = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam int ARB_TMO_W = 16;

    function automatic int idx_w(input int n);
        int w;
        w = $clog2(n);
        if (w < 1) begin
            return 1;
        end else begin
            return w;
        end
    endfunction

endpackage

// File: rtl/ahbuart_rr_pick.sv
// Combinational round-robin picker: the search starts one past the last grant
// and wraps modulo NREQ.
module ahbuart_rr_pick
    import ahbuart_arb_pkg::*;
#(
    parameter  int NREQ = 2,
    localparam int IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic            any,
    output logic [IW-1:0]   winner
);

    localparam logic [IW:0] NREQ_V = (IW+1)'(NREQ);

    logic [IW-1:0]   start_s;
    logic [NREQ-1:0] rot_s;
    logic [IW-1:0]   off_s;
    logic            found_s;
    logic [IW:0]     sum_s;

    assign any = |req;

    // rotate so the start position sits at bit 0, take the lowest set bit, rotate back
    always_comb begin
        if ({1'b0, last} >= NREQ_V - (IW+1)'(1)) begin
            start_s = '0;
        end else begin
            start_s = last + IW'(1);
        end
        rot_s   = NREQ'({req, req} >> start_s);
        off_s   = '0;
        found_s = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found_s && rot_s[i]) begin
                off_s   = IW'(i);
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
        sum_s = {1'b0, off_s} + {1'b0, start_s};
        if (sum_s >= NREQ_V) begin
            winner = IW'(sum_s - NREQ_V);
        end else begin
            winner = IW'(sum_s);
        end
    end

endmodule

// File: rtl/ahbuart_bus_arbiter.sv
// Round-robin arbiter and single-word transfer sequencer for the shared AHB-side port.
// Optional bus-wait timeout is enabled by defining AHBUART_ARB_TIMEOUT_EN.
module ahbuart_bus_arbiter
    import ahbuart_arb_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TMO_CYC = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  req_write,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]  done,
    output logic [DW-1:0]    rsp_rdata,
    output logic             rsp_err,
    output logic             bus_valid,
    input  logic             bus_ready,
    output logic             bus_write,
    output logic [AW-1:0]    bus_addr,
    output logic [DW-1:0]    bus_wdata,
    input  logic [DW-1:0]    bus_rdata,
    input  logic             bus_err
);

    localparam int IW = idx_w(NREQ);

    if (NREQ < 2 || NREQ > 8 || TMO_CYC < 1 || TMO_CYC > (2 ** ARB_TMO_W) - 1) begin : g_param_check
        $error("ahbuart_bus_arbiter: parameter out of range");
    end

    arb_state_t    state_r;
    arb_state_t    next_s;
    logic          any_s;
    logic [IW-1:0] pick_s;
    logic [IW-1:0] winner_r;
    logic [IW-1:0] last_r;
    logic          accept_s;
    logic          tmo_s;
    logic          exit_s;

    ahbuart_rr_pick #(.NREQ(NREQ)) u_pick (
        .req    (req),
        .last   (last_r),
        .any    (any_s),
        .winner (pick_s)
    );

    assign accept_s = (state_r == BUS) && bus_ready;
    assign exit_s   = accept_s || tmo_s;

`ifdef AHBUART_ARB_TIMEOUT_EN
    logic [ARB_TMO_W-1:0] tmo_cnt_r;

    // ready wins over a timeout landing on the same cycle
    assign tmo_s = (state_r == BUS) && !bus_ready
                   && (tmo_cnt_r == ARB_TMO_W'(TMO_CYC - 1));

    // bus-wait counter, cleared in GRANT so every BUS visit starts from zero
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt_r <= '0;
        end else if (state_r == GRANT) begin
            tmo_cnt_r <= '0;
        end else if (state_r == BUS && !bus_ready) begin
            tmo_cnt_r <= tmo_cnt_r + ARB_TMO_W'(1);
        end else begin
            tmo_cnt_r <= tmo_cnt_r;
        end
    end
`else
    assign tmo_s = 1'b0;
`endif

    // next-state logic
    always_comb begin
        next_s = state_r;
        case (state_r)
            IDLE: begin
                if (any_s) begin
                    next_s = GRANT;
                end else begin
                    next_s = IDLE;
                end
            end
            GRANT: next_s = BUS;
            BUS: begin
                if (exit_s) begin
                    next_s = RESP;
                end else begin
                    next_s = BUS;
                end
            end
            RESP:    next_s = IDLE;
            default: next_s = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // winner capture and bus fields; fields are loaded from the winner in GRANT and zeroed on exit
    always_ff @(posedge clk) begin
        if (reset) begin
            winner_r  <= '0;
            last_r    <= IW'(NREQ - 1);
            bus_valid <= 1'b0;
            bus_write <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
        end else begin
            if (state_r == IDLE && any_s) begin
                winner_r <= pick_s;
            end
            if (state_r == GRANT) begin
                last_r    <= winner_r;
                bus_valid <= 1'b1;
                bus_write <= req_write[winner_r];
                bus_addr  <= req_addr[winner_r*AW +: AW];
                bus_wdata <= req_wdata[winner_r*DW +: DW];
            end else if (exit_s) begin
                bus_valid <= 1'b0;
                bus_write <= 1'b0;
                bus_addr  <= '0;
                bus_wdata <= '0;
            end
        end
    end

    // completion pulse and response capture, held until the next acceptance
    always_ff @(posedge clk) begin
        if (reset) begin
            done      <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (exit_s) begin
                done <= NREQ'(1'b1) << winner_r;
            end else begin
                done <= '0;
            end
            if (accept_s) begin
                rsp_rdata <= bus_write ? '0 : bus_rdata;
                rsp_err   <= bus_err;
            end else if (tmo_s) begin
                rsp_rdata <= '0;
                rsp_err   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ahbuart_bus_arbiter.sv
// Directed self-checking bench for ahbuart_bus_arbiter (two-requester and four-requester builds).
module tb_ahbuart_bus_arbiter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // two-requester instance
    logic [1:0]  r2_req, r2_write;
    logic [63:0] r2_addr, r2_wdata;
    logic        b2_ready, b2_err;
    logic [31:0] b2_rdata;
    logic [1:0]  d2_done;
    logic [31:0] d2_rdata, d2_addr, d2_wdata;
    logic        d2_err, d2_valid, d2_write;

    // four-requester instance
    logic [3:0]   r4_req, r4_write;
    logic [127:0] r4_addr, r4_wdata;
    logic         b4_ready, b4_err;
    logic [31:0]  b4_rdata;
    logic [3:0]   d4_done;
    logic [31:0]  d4_rdata, d4_addr, d4_wdata;
    logic         d4_err, d4_valid, d4_write;

    int checks   = 0;
    int failures = 0;

    ahbuart_bus_arbiter #(.NREQ(2), .AW(32), .DW(32), .TMO_CYC(10)) u_dut2 (
        .clk(clk), .reset(reset), .req(r2_req), .req_write(r2_write),
        .req_addr(r2_addr), .req_wdata(r2_wdata), .done(d2_done),
        .rsp_rdata(d2_rdata), .rsp_err(d2_err), .bus_valid(d2_valid),
        .bus_ready(b2_ready), .bus_write(d2_write), .bus_addr(d2_addr),
        .bus_wdata(d2_wdata), .bus_rdata(b2_rdata), .bus_err(b2_err)
    );

    ahbuart_bus_arbiter #(.NREQ(4), .AW(32), .DW(32), .TMO_CYC(10)) u_dut4 (
        .clk(clk), .reset(reset), .req(r4_req), .req_write(r4_write),
        .req_addr(r4_addr), .req_wdata(r4_wdata), .done(d4_done),
        .rsp_rdata(d4_rdata), .rsp_err(d4_err), .bus_valid(d4_valid),
        .bus_ready(b4_ready), .bus_write(d4_write), .bus_addr(d4_addr),
        .bus_wdata(d4_wdata), .bus_rdata(b4_rdata), .bus_err(b4_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset    = 1'b1;
        r2_req   = 2'b00;  r2_write = 2'b00; r2_addr = 64'h0; r2_wdata = 64'h0;
        b2_ready = 1'b0;   b2_err   = 1'b0;  b2_rdata = 32'h0;
        r4_req   = 4'b0000; r4_write = 4'b0000; r4_addr = 128'h0; r4_wdata = 128'h0;
        b4_ready = 1'b0;   b4_err   = 1'b0;  b4_rdata = 32'h0;

        // reset state
        step; step;
        chk("rst_valid", d2_valid, 64'h0);
        chk("rst_done", d2_done, 64'h0);
        chk("rst_addr", d2_addr, 64'h0);
        chk("rst_wdata", d2_wdata, 64'h0);
        chk("rst_write", d2_write, 64'h0);
        chk("rst_rdata", d2_rdata, 64'h0);
        chk("rst_err", d2_err, 64'h0);
        chk("rst4_valid", d4_valid, 64'h0);
        chk("rst4_done", d4_done, 64'h0);
        reset = 1'b0;

        // single read, ready at once
        r2_req = 2'b01; r2_write = 2'b00; r2_addr[31:0] = 32'h100;
        b2_ready = 1'b1; b2_rdata = 32'hDEADBEEF; b2_err = 1'b0;
        step; chk("t1_grant_valid", d2_valid, 64'h0);
        step; chk("t1_bus_valid", d2_valid, 64'h1);
              chk("t1_bus_addr", d2_addr, 64'h100);
              chk("t1_bus_write", d2_write, 64'h0);
        step; chk("t1_valid_drop", d2_valid, 64'h0);
              chk("t1_done", d2_done, 64'h1);
              chk("t1_rdata", d2_rdata, 64'hDEADBEEF);
              chk("t1_err", d2_err, 64'h0);
        r2_req = 2'b00;
        step; chk("t1_done_clear", d2_done, 64'h0);
              chk("t1_rdata_hold", d2_rdata, 64'hDEADBEEF);

        // fairness from reset: 0,1,0,1
        reset = 1'b1; step; reset = 1'b0;
        r2_addr = {32'h14, 32'h10}; r2_req = 2'b11; b2_rdata = 32'h1111_2222;
        for (int t = 0; t < 4; t++) begin
            step; chk("t2_grant_valid", d2_valid, 64'h0);
            step; chk("t2_valid", d2_valid, 64'h1);
                  chk("t2_addr", d2_addr, ((t % 2) == 0) ? 64'h10 : 64'h14);
            step; chk("t2_done", d2_done, ((t % 2) == 0) ? 64'h1 : 64'h2);
            if (t == 3) r2_req = 2'b00;
            step; chk("t2_done_clear", d2_done, 64'h0);
        end

        // write with 7 stall cycles; fields stay latched while inputs change
        r2_req = 2'b01; r2_write = 2'b01; r2_addr[31:0] = 32'h20; r2_wdata[31:0] = 32'h5A5A5A5A;
        b2_ready = 1'b0; b2_rdata = 32'hCAFEF00D;
        step;
        for (int i = 0; i < 8; i++) begin
            step; chk("t3_valid", d2_valid, 64'h1);
                  chk("t3_addr", d2_addr, 64'h20);
                  chk("t3_wdata", d2_wdata, 64'h5A5A5A5A);
                  chk("t3_write", d2_write, 64'h1);
                  chk("t3_no_done", d2_done, 64'h0);
            r2_addr[31:0] = 32'hFFF;
        end
        b2_ready = 1'b1;
        step; chk("t3_done", d2_done, 64'h1);
              chk("t3_rdata_zero", d2_rdata, 64'h0);
              chk("t3_err", d2_err, 64'h0);
              chk("t3_valid_drop", d2_valid, 64'h0);
              chk("t3_addr_zero", d2_addr, 64'h0);
        r2_req = 2'b00; r2_write = 2'b00;
        step; chk("t3_done_clear", d2_done, 64'h0);

`ifdef AHBUART_ARB_TIMEOUT_EN
        // timeout after 10 BUS cycles
        r2_req = 2'b01; r2_addr[31:0] = 32'h300; b2_ready = 1'b0; b2_rdata = 32'hBAD0BAD0;
        step;
        for (int i = 0; i < 10; i++) begin
            step; chk("t5_valid", d2_valid, 64'h1);
        end
        step; chk("t5_valid_drop", d2_valid, 64'h0);
              chk("t5_done", d2_done, 64'h1);
              chk("t5_err", d2_err, 64'h1);
              chk("t5_rdata", d2_rdata, 64'h0);
        r2_req = 2'b00;
        step; chk("t5_done_clear", d2_done, 64'h0);
        // ready on the timeout cycle wins
        r2_req = 2'b01;
        step;
        for (int i = 0; i < 10; i++) begin
            step; chk("t5b_valid", d2_valid, 64'h1);
        end
        b2_ready = 1'b1; b2_rdata = 32'hA5A50001; b2_err = 1'b0;
        step; chk("t5b_done", d2_done, 64'h1);
              chk("t5b_err", d2_err, 64'h0);
              chk("t5b_rdata", d2_rdata, 64'hA5A50001);
        r2_req = 2'b00; b2_ready = 1'b0;
        step;
`else
        // without the timeout the bus wait is unbounded
        r2_req = 2'b01; r2_addr[31:0] = 32'h300; b2_ready = 1'b0;
        step;
        for (int i = 0; i < 20; i++) begin
            step; chk("t5_wait_valid", d2_valid, 64'h1);
        end
        b2_ready = 1'b1; b2_rdata = 32'hA5A50001;
        step; chk("t5_wait_done", d2_done, 64'h1);
              chk("t5_wait_rdata", d2_rdata, 64'hA5A50001);
        r2_req = 2'b00;
        step;
`endif

        // normal read by requester 1
        r2_req = 2'b10; r2_addr[63:32] = 32'h80; b2_ready = 1'b1; b2_rdata = 32'h12345678; b2_err = 1'b0;
        step;
        step; chk("t5n_valid", d2_valid, 64'h1);
              chk("t5n_addr", d2_addr, 64'h80);
        step; chk("t5n_done", d2_done, 64'h2);
              chk("t5n_rdata", d2_rdata, 64'h12345678);
              chk("t5n_err", d2_err, 64'h0);
        r2_req = 2'b00;
        step;

        // reset while bus_valid is high
        r2_addr = {32'h44, 32'h40}; r2_req = 2'b01; b2_ready = 1'b0;
        step;
        step; chk("t4_valid", d2_valid, 64'h1);
              chk("t4_addr", d2_addr, 64'h40);
        reset = 1'b1;
        step; chk("t4_rst_valid", d2_valid, 64'h0);
              chk("t4_rst_done", d2_done, 64'h0);
              chk("t4_rst_addr", d2_addr, 64'h0);
              chk("t4_rst_rdata", d2_rdata, 64'h0);
              chk("t4_rst_err", d2_err, 64'h0);
        reset = 1'b0; r2_req = 2'b11; b2_ready = 1'b1; b2_rdata = 32'h600DF00D;
        step; chk("t4_grant_no_done", d2_done, 64'h0);
        step; chk("t4_first_addr", d2_addr, 64'h40);
        step; chk("t4_first_done", d2_done, 64'h1);
              chk("t4_first_rdata", d2_rdata, 64'h600DF00D);
        r2_req = 2'b10; b2_err = 1'b1;
        step;
        step;
        step; chk("t4_second_addr", d2_addr, 64'h44);
        step; chk("t4_second_done", d2_done, 64'h2);
              chk("t4_second_err", d2_err, 64'h1);
        r2_req = 2'b00; b2_err = 1'b0;
        step;

        // four requesters: requester 3 withdraws before arbitration
        r4_addr = {32'h430, 32'h420, 32'h410, 32'h400};
        r4_req = 4'b0001; b4_ready = 1'b0;
        step;
        step; chk("t6_first_addr", d4_addr, 64'h400);
        r4_req = 4'b1011;
        step; step;
        r4_req = 4'b0011; b4_ready = 1'b1;
        step; chk("t6_first_done", d4_done, 64'h1);
        r4_req = 4'b0010;
        step; chk("t6_idle_done", d4_done, 64'h0);
        step;
        step; chk("t6_second_valid", d4_valid, 64'h1);
              chk("t6_second_addr", d4_addr, 64'h410);
        step; chk("t6_second_done", d4_done, 64'h2);
        r4_req = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            step; chk("t6_no_done3", d4_done, 64'h0);
                  chk("t6_no_valid", d4_valid, 64'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ahbuart_bus_arbiter.md
# ahbuart_bus_arbiter

Round-robin arbiter and transfer sequencer that shares the single AHB-side master port of the ahbuart out-of-order test design between several requesters (UART debug link, on-chip test stimulus, random-number-driven exerciser). It accepts one single-word transfer request per requester, picks a winner fairly, and drives a valid/ready transfer to the bus port. It sequences the transfer to completion and returns read data and error status to the winner only.

## Interface
- `NREQ`, 2: number of requesters, 2–8.
- `AW`, 32: address width.
- `DW`, 32: data width.
- `TMO_CYC`, 255: bus-wait timeout in cycles, 1–65535; used only with the timeout feature.
- `clk  in  1`: single clock; all logic is on its rising edge.
- `reset  in  1`: synchronous, active-high.
- `req  in  NREQ`: per-requester request; held high until the matching `done` bit.
- `req_write  in  NREQ`: 1 = write, 0 = read.
- `req_addr  in  NREQ*AW`: packed addresses; requester i occupies `[i*AW +: AW]`.
- `req_wdata  in  NREQ*DW`: packed write data.
- `done  out  NREQ`: one-hot, one-cycle completion pulse.
- `rsp_rdata  out  DW`: read data; valid while `done` is high.
- `rsp_err  out  1`: error flag; valid while `done` is high.
- `bus_valid  out  1`: transfer request to the bus.
- `bus_ready  in  1`: bus accepts and completes the transfer in the same cycle.
- `bus_write  out  1`, `bus_addr  out  AW`, `bus_wdata  out  DW`: transfer fields.
- `bus_rdata  in  DW`, `bus_err  in  1`: sampled when `bus_valid && bus_ready`.

## Operation
- States:
  - IDLE: wait for any `req` bit.
  - GRANT: latch the winner index and its `req_write`, `req_addr` and `req_wdata` into registers.
  - BUS: hold `bus_valid` high until `bus_ready`.
  - RESP: pulse `done[winner]`.
- Transitions:
  - IDLE→GRANT when `|req`.
  - GRANT→BUS always.
  - BUS→RESP on `bus_ready`, or on timeout.
  - RESP→IDLE always.
- Arbitration: round-robin starting at `last_grant+1` mod NREQ. `last_grant` updates in GRANT; its reset value is NREQ-1, so requester 0 has first priority after reset.
- Bus fields come from the latched registers. Requester inputs may change after GRANT without affecting the transfer in flight.
- Response data and error:
  - `rsp_rdata` and `rsp_err` are registered from `bus_rdata` and `bus_err` on the accepting cycle and held until the next acceptance.
  - On a write, `rsp_rdata` is driven to 0.
- A requester whose `req` drops before winning is simply skipped. A requester whose `req` drops after GRANT still receives its `done`.
- Outputs are never X: all registers reset, and the bus fields are zero outside BUS.

## Timing
- Reset values: state=IDLE; `done`=0, `bus_valid`=0, `bus_write`=0, `bus_addr`=0, `bus_wdata`=0, `rsp_rdata`=0, `rsp_err`=0; `last_grant`=NREQ-1; timeout counter=0.
- Latency:
  - `req` rising in IDLE at cycle n gives `bus_valid` at n+2.
  - With `bus_ready` high at n+2, `done` pulses at n+3.
  - Minimum cycle-to-cycle repetition for back-to-back requests is 4 cycles.
- `bus_valid` and the bus fields are stable from assertion until `bus_ready`; there is no withdrawal.
- Reset mid-BUS: `bus_valid` is 0 on the next cycle and no `done` is produced. The interrupted requester must re-request.
- Simultaneous requests: only one is granted per arbitration. The others wait, and each waits at most NREQ-1 transfers.
- In RESP, arbitration does not happen. A `req` asserted during RESP is considered in the following IDLE.

## Configuration
- Macro: `AHBUART_ARB_TIMEOUT_EN`.
- When defined:
  - A 16-bit counter clears on BUS entry and increments each BUS cycle without `bus_ready`.
  - When the counter reaches `TMO_CYC`, the block drops `bus_valid`, moves to RESP, and drives `rsp_err`=1 and `rsp_rdata`=0.
  - If `bus_ready` arrives in the same cycle as the timeout, the ready wins and `rsp_err` follows `bus_err`.
- When undefined:
  - No counter is implemented and BUS waits indefinitely.
  - `TMO_CYC` is ignored.

## Structure
- Package `ahbuart_arb_pkg`:
  - `arb_state_t` enum (IDLE, GRANT, BUS, RESP).
  - `ARB_TMO_W` = 16.
  - Function `idx_w(n)` returning `$clog2(n)`, minimum 1.
- Sub-module `ahbuart_rr_pick`:
  - Purely combinational.
  - Inputs: `req[NREQ]` and `last[idx_w]`.
  - Outputs: `any` and `winner[idx_w]`.
  - Uses rotate, priority-encode, then un-rotate.
- The top contains the FSM, the latch registers and the timeout counter.

## Test plan
- Single read: NREQ=2, `req`=01, read at 0x100, `bus_ready` high at once with `bus_rdata`=0xDEADBEEF → `bus_valid` for 1 cycle, `done`=01 at n+3, `rsp_rdata`=0xDEADBEEF, `rsp_err`=0.
- Fairness: `req`=11 held continuously for 4 transfers → grant order 0,1,0,1; each `done` bit pulses twice.
- Bus stall: write of 0x5A5A5A5A to 0x20, `bus_ready` low for 7 cycles → `bus_valid` and fields stable for 8 cycles, `done` one cycle after `bus_ready`, `rsp_rdata`=0.
- Timeout (macro on, `TMO_CYC`=10): `bus_ready` never asserts → `bus_valid` deasserts after 10 BUS cycles, `done` pulses with `rsp_err`=1; a later request proceeds normally.
- Reset mid-BUS: assert `reset` for 1 cycle while `bus_valid`=1 → next cycle all outputs are at reset values and no `done` pulse appears; after reset, requester 0 wins first.
- Request withdrawn: NREQ=4, `req`=1000 dropped to 0 the cycle before arbitration, while `req`=0010 is pending → requester 1 is granted and requester 3 gets no `done`.
